// File: rtl/edge_line_sequencer.sv
// Row sequencer for the 3x3 edge filter: buffers the two previous raster
// lines and presents rows y-2, y-1 and y column-aligned, with valid held low
// until a frame has delivered two complete lines.
module edge_line_sequencer #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned MAX_WIDTH  = 1024,
  parameter int unsigned CNT_WIDTH  = $clog2(MAX_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data0_o,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o,
  output logic [CNT_WIDTH-1:0]  width_o,
  output logic                  ovf_o
);

  localparam int unsigned ADDR_WIDTH = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] COL_MAX = CNT_WIDTH'(MAX_WIDTH);

  // Frame fill state: two lines must land in the memories before output runs
  localparam logic [1:0] WAIT_VS = 2'd0;
  localparam logic [1:0] FILL0   = 2'd1;
  localparam logic [1:0] FILL1   = 2'd2;
  localparam logic [1:0] RUN     = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_WIDTH-1:0]  col;
  logic [CNT_WIDTH-1:0]  col_nxt;
  logic                  sel;
  logic                  sel_nxt;
  logic                  line_act;
  logic                  line_act_nxt;
  logic [CNT_WIDTH-1:0]  width_nxt;
  logic                  ovf_nxt;

  // sel=0: L0 holds row y-2 (written this line), L1 holds row y-1
  logic [DATA_WIDTH-1:0] mem0 [0:MAX_WIDTH-1];
  logic [DATA_WIDTH-1:0] mem1 [0:MAX_WIDTH-1];

  logic                  vs_rise_c;
  logic                  de_eff_c;
  logic                  active_c;
  logic                  pix_c;
  logic                  in_range_c;
  logic                  wr_c;
  logic                  eol_c;
  logic                  out_en_c;
  logic [ADDR_WIDTH-1:0] addr_c;

  assign vs_rise_c  = vsync_i & ~vsync_o;
  assign de_eff_c   = de_i & ~vsync_i;
  assign active_c   = (state != WAIT_VS);
  assign pix_c      = de_eff_c & active_c;
  assign in_range_c = (col < COL_MAX);
  assign wr_c       = pix_c & in_range_c & ~rst;
  assign eol_c      = active_c & line_act & ~de_eff_c & ~vs_rise_c;
  assign out_en_c   = de_eff_c & (state == RUN);
  assign addr_c     = col[ADDR_WIDTH-1:0];

  // Next-state and control decode; a vsync rise overrides everything and aborts the line
  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    sel_nxt      = sel;
    width_nxt    = width_o;
    ovf_nxt      = ovf_o;
    line_act_nxt = pix_c;
    if (vs_rise_c) begin
      state_nxt    = FILL0;
      col_nxt      = '0;
      sel_nxt      = 1'b0;
      ovf_nxt      = 1'b0;
      line_act_nxt = 1'b0;
    end else begin
      if (eol_c) begin
        sel_nxt   = ~sel;
        col_nxt   = '0;
        width_nxt = col;
        case (state)
          FILL0:   state_nxt = FILL1;
          FILL1:   state_nxt = RUN;
          default: state_nxt = state;
        endcase
      end
      if (pix_c) begin
        if (in_range_c) begin
          col_nxt = col + CNT_WIDTH'(1);
        end else begin
          ovf_nxt = 1'b1;
        end
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_VS;
      col      <= '0;
      sel      <= 1'b0;
      line_act <= 1'b0;
      width_o  <= '0;
      ovf_o    <= 1'b0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      sel      <= sel_nxt;
      line_act <= line_act_nxt;
      width_o  <= width_nxt;
      ovf_o    <= ovf_nxt;
    end
  end

  // Line memory write into the y-2 memory; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_c) begin
      if (sel) begin
        mem1[addr_c] <= data_i;
      end else begin
        mem0[addr_c] <= data_i;
      end
    end
  end

  // Registered read and output alignment; data holds whenever de_o is low
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_o <= 1'b0;
      de_o    <= 1'b0;
      data0_o <= '0;
      data1_o <= '0;
      data2_o <= '0;
    end else begin
      vsync_o <= vsync_i;
      de_o    <= out_en_c;
      if (out_en_c) begin
        data2_o <= data_i;
        if (in_range_c) begin
          data0_o <= sel ? mem1[addr_c] : mem0[addr_c];
          data1_o <= sel ? mem0[addr_c] : mem1[addr_c];
        end else begin
          data0_o <= '0;
          data1_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_line_sequencer.sv
// Bench for edge_line_sequencer: directed raster traffic, a line-history
// reference model checked every cycle, plus hand-computed spot values.
module tb_edge_line_sequencer;

  localparam int DW   = 10;
  localparam int MAXW = 16;
  localparam int CW   = 5;

  logic          clk;
  logic          rst;
  logic          vsync_i;
  logic          de_i;
  logic [DW-1:0] data_i;
  logic          vsync_o;
  logic          de_o;
  logic [DW-1:0] data0_o;
  logic [DW-1:0] data1_o;
  logic [DW-1:0] data2_o;
  logic [CW-1:0] width_o;
  logic          ovf_o;

  edge_line_sequencer #(
    .DATA_WIDTH(DW),
    .MAX_WIDTH (MAXW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .vsync_i(vsync_i),
    .de_i   (de_i),
    .data_i (data_i),
    .vsync_o(vsync_o),
    .de_o   (de_o),
    .data0_o(data0_o),
    .data1_o(data1_o),
    .data2_o(data2_o),
    .width_o(width_o),
    .ovf_o  (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int de_cnt   = 0;
  logic chk_en = 1'b0;

  // Model state: two line memories, which one holds row y-2, frame progress
  logic [DW-1:0] m [0:1][0:MAXW-1];
  logic          old_m;
  logic          armed;
  logic          in_line;
  logic          prev_vs;
  int            nlines;
  int            mcol;

  // Expected outputs (exp_*) and their next-cycle values (nx_*)
  logic          exp_vs, exp_de, exp_ovf;
  logic [DW-1:0] exp_d0, exp_d1, exp_d2;
  logic [CW-1:0] exp_w;
  logic          nx_vs, nx_de, nx_ovf;
  logic [DW-1:0] nx_d0, nx_d1, nx_d2;
  logic [CW-1:0] nx_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: one input cycle -> outputs expected after the next clock edge
  task automatic model_step(input logic r, input logic v, input logic e, input logic [DW-1:0] d);
    logic rise;
    logic pix;
    if (r) begin
      nx_vs = 0; nx_de = 0; nx_d0 = 0; nx_d1 = 0; nx_d2 = 0; nx_w = 0; nx_ovf = 0;
      armed = 0; nlines = 0; in_line = 0; mcol = 0; old_m = 0; prev_vs = 0;
    end else begin
      rise    = v && !prev_vs;
      prev_vs = v;
      nx_vs   = v;
      pix     = e && !v && armed;
      nx_de   = pix && (nlines >= 2);
      if (rise) begin
        armed = 1; nlines = 0; in_line = 0; mcol = 0; old_m = 0; nx_ovf = 0;
      end else if (armed) begin
        if (in_line && !pix) begin
          nx_w    = CW'(mcol);
          old_m   = !old_m;
          mcol    = 0;
          in_line = 0;
          if (nlines < 2) nlines++;
        end
        if (pix) begin
          in_line = 1;
          if (mcol < MAXW) begin
            if (nx_de) begin
              nx_d0 = m[old_m][mcol];
              nx_d1 = m[!old_m][mcol];
              nx_d2 = d;
            end
            m[old_m][mcol] = d;
            mcol++;
          end else begin
            if (nx_de) begin
              nx_d0 = 0;
              nx_d1 = 0;
              nx_d2 = d;
            end
            nx_ovf = 1;
          end
        end
      end
    end
  endtask

  // One clock of stimulus; returns just after the edge with expectations updated
  task automatic step(input logic r, input logic v, input logic e, input logic [DW-1:0] d);
    @(negedge clk);
    rst = r; vsync_i = v; de_i = e; data_i = d;
    model_step(r, v, e, d);
    @(posedge clk);
    #1;
    exp_vs = nx_vs; exp_de = nx_de; exp_ovf = nx_ovf;
    exp_d0 = nx_d0; exp_d1 = nx_d1; exp_d2 = nx_d2; exp_w = nx_w;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (de_o === 1'b1) de_cnt++;
    if (chk_en) begin
      chk("vsync_o", 32'(vsync_o), 32'(exp_vs));
      chk("de_o",    32'(de_o),    32'(exp_de));
      chk("data0_o", 32'(data0_o), 32'(exp_d0));
      chk("data1_o", 32'(data1_o), 32'(exp_d1));
      chk("data2_o", 32'(data2_o), 32'(exp_d2));
      chk("width_o", 32'(width_o), 32'(exp_w));
      chk("ovf_o",   32'(ovf_o),   32'(exp_ovf));
    end
  end

  task automatic vsync_pulse();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  // Sends one line; at column cx pins both DUT and model to literal values
  task automatic send_line(input int base, input int width, input int gap, input int cx,
                           input int e0, input int e1, input int e2);
    de_cnt = 0;
    for (int x = 0; x < width; x++) begin
      step(0, 0, 1, DW'(base + x));
      if (x == cx) begin
        chk("lit_d0", 32'(data0_o), 32'(e0));
        chk("lit_d1", 32'(data1_o), 32'(e1));
        chk("lit_d2", 32'(data2_o), 32'(e2));
        chk("model_d0", 32'(exp_d0), 32'(e0));
        chk("model_d2", 32'(exp_d2), 32'(e2));
      end
    end
    for (int g = 0; g < gap; g++) step(0, 0, 0, 0);
  endtask

  task automatic four_lines(input int gap);
    for (int n = 0; n < 4; n++) begin
      if (n == 2)      send_line(16 * n, 8, gap, 3, 'h03, 'h13, 'h23);
      else if (n == 3) send_line(16 * n, 8, gap, 3, 'h13, 'h23, 'h33);
      else             send_line(16 * n, 8, gap, -1, 0, 0, 0);
      chk("de_count", 32'(de_cnt), (n < 2) ? 32'd0 : 32'd8);
    end
    chk("width_8", 32'(width_o), 32'd8);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < MAXW; j++) m[i][j] = '0;
    rst = 1; vsync_i = 0; de_i = 0; data_i = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_de", 32'(de_o), 32'd0);
    chk("rst_width", 32'(width_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    step(0, 0, 0, 0);

    // Four lines, 2-cycle gaps, then 1-cycle gaps
    vsync_pulse();
    four_lines(2);
    vsync_pulse();
    four_lines(1);

    // Overflow line in RUN after two full-width lines
    vsync_pulse();
    send_line('h80, MAXW, 2, -1, 0, 0, 0);
    send_line('hA0, MAXW, 2, -1, 0, 0, 0);
    de_cnt = 0;
    for (int x = 0; x < MAXW + 3; x++) begin
      step(0, 0, 1, DW'('h100 + x));
      if (x == MAXW - 1) chk("ovf_before", 32'(ovf_o), 32'd0);
      if (x == MAXW) begin
        chk("ovf_set", 32'(ovf_o), 32'd1);
        chk("ovf_d0", 32'(data0_o), 32'd0);
        chk("ovf_d1", 32'(data1_o), 32'd0);
        chk("ovf_d2", 32'(data2_o), 32'h110);
      end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("ovf_width", 32'(width_o), 32'(MAXW));
    chk("ovf_de_count", 32'(de_cnt), 32'(MAXW + 3));
    chk("ovf_sticky", 32'(ovf_o), 32'd1);
    step(0, 1, 0, 0);
    chk("ovf_clear", 32'(ovf_o), 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Vsync rising in the middle of the third line
    send_line('h40, 8, 2, -1, 0, 0, 0);
    send_line('h50, 8, 2, -1, 0, 0, 0);
    for (int x = 0; x < 4; x++) step(0, 0, 1, DW'('h60 + x));
    step(0, 1, 1, DW'('h64));
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("abort_width", 32'(width_o), 32'd8);
    for (int n = 0; n < 3; n++) begin
      if (n == 2) send_line(16 * n, 8, 2, 3, 'h03, 'h13, 'h23);
      else        send_line(16 * n, 8, 2, -1, 0, 0, 0);
      chk("abort_de_count", 32'(de_cnt), (n < 2) ? 32'd0 : 32'd8);
    end

    // Reset pulse mid-line during RUN
    for (int x = 0; x < 3; x++) step(0, 0, 1, DW'('h70 + x));
    step(1, 0, 1, DW'('h73));
    chk("mrst_de", 32'(de_o), 32'd0);
    chk("mrst_d2", 32'(data2_o), 32'd0);
    chk("mrst_width", 32'(width_o), 32'd0);
    step(0, 0, 0, 0);
    for (int n = 0; n < 2; n++) begin
      send_line('h20 * n, 8, 2, -1, 0, 0, 0);
      chk("nosync_de_count", 32'(de_cnt), 32'd0);
    end
    chk("nosync_width", 32'(width_o), 32'd0);
    vsync_pulse();
    for (int n = 0; n < 3; n++) begin
      if (n == 2) send_line(16 * n, 8, 2, 3, 'h03, 'h13, 'h23);
      else        send_line(16 * n, 8, 2, -1, 0, 0, 0);
    end
    chk("resume_de_count", 32'(de_cnt), 32'd8);

    // Vsync and de_i asserted in the same cycle
    step(0, 1, 1, DW'('h3FF));
    chk("vsde_de", 32'(de_o), 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    send_line(0, 8, 2, -1, 0, 0, 0);
    chk("vsde_width", 32'(width_o), 32'd8);
    send_line(16, 8, 2, -1, 0, 0, 0);
    send_line(32, 8, 2, 3, 'h03, 'h13, 'h23);
    chk("vsde_de_count", 32'(de_cnt), 32'd8);

    step(0, 0, 0, 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
